serial_tx_scheduler: RTL and testbench

Schedules and shares the single byte-level serial transmitter between several frame requesters, such as the apple-eaten event, the periodic game-state frame and debug telemetry.
- Arbitrates round-robin between requesters.
- On grant, latches the whole frame.
- Sequences its bytes through a start/done handshake and appends a terminator byte.
- Enforces a minimum inter-frame gap and a per-byte timeout.
- Sits between the SGA game datapath and the serial transmitter.

---
 rtl/sga_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/serial_tx_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_serial_tx_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sga_pkg.sv
// Shared definitions for the serial frame scheduler: state encodings and frame constants.
// SERIAL_TX_SCHEDULER_CHECKSUM_EN adds the checksum state CHK.
package sga_pkg;

    localparam int LEN_W = 3;
    localparam logic [7:0] TERM_BYTE_DEFAULT = 8'h23;

    // Encodings double as the debug value shown on the seven-segment display.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT      = 3'd3,
        ST_TERM      = 3'd4,
        ST_WAIT_TERM = 3'd5,
`ifdef SERIAL_TX_SCHEDULER_CHECKSUM_EN
        ST_GAP       = 3'd6,
        ST_CHK       = 3'd7
`else
        ST_GAP       = 3'd6
`endif
    } tx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or after
// the pointer, wrapping around.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         grant_idx
);

    logic [1:0] cand [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [2:0] sum;
            assign sum      = {1'b0, ptr} + 3'(gi);
            assign cand[gi] = (sum >= 3'(NUM_REQ)) ? 2'(sum - 3'(NUM_REQ)) : sum[1:0];
        end
    endgenerate

    logic found;

    // Scan from the farthest candidate back so the nearest one to the pointer wins.
    always_comb begin
        grant_idx = 2'd0;
        grant     = '0;
        found     = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                grant_idx = cand[k];
                found     = 1'b1;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Shares one byte-level serial transmitter between several frame requesters.
// Define SERIAL_TX_SCHEDULER_CHECKSUM_EN to append an XOR checksum byte before the terminator.
import sga_pkg::*;

module serial_tx_scheduler #(
    parameter int         NUM_REQ        = 3,
    parameter int         MAX_BYTES      = 4,
    parameter int         GAP_CYCLES     = 50,
    parameter int         TIMEOUT_CYCLES = 2000000,
    parameter logic [7:0] TERM_BYTE      = TERM_BYTE_DEFAULT
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*LEN_W-1:0]       req_len,
    input  logic [NUM_REQ*MAX_BYTES*8-1:0] req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           tx_start,
    output logic [7:0]                     tx_data,
    input  logic                           tx_done,
    output logic                           busy,
    output logic [1:0]                     grant_id,
    output logic                           timeout_err,
    output logic [2:0]                     db_state
);

    localparam int PAY_W     = MAX_BYTES * 8;
    localparam int CNT_LIMIT = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W     = $clog2(CNT_LIMIT + 1);

`ifdef SERIAL_TX_SCHEDULER_CHECKSUM_EN
    localparam tx_state_t ST_AFTER_PAYLOAD = ST_CHK;
`else
    localparam tx_state_t ST_AFTER_PAYLOAD = ST_TERM;
`endif

    tx_state_t          state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [LEN_W-1:0]   idx_reg, len_reg;
    logic [PAY_W-1:0]   payload_reg;
    logic [1:0]         grant_id_reg, ptr_reg;
`ifdef SERIAL_TX_SCHEDULER_CHECKSUM_EN
    logic [7:0]         chk_reg;
    logic               in_chk_reg;
`endif

    logic [NUM_REQ-1:0] arb_grant;
    logic [1:0]         arb_idx;
    logic               arb_any;
    logic [LEN_W-1:0]   sel_len_raw, sel_len, idx_inc;
    logic [PAY_W-1:0]   sel_data;
    logic [7:0]         cur_byte;
    logic               timeout_hit, gap_done, last_byte, counting;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req),
        .ptr       (ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign arb_any     = |arb_grant;
    assign sel_len_raw = req_len[grant_id_reg*LEN_W +: LEN_W];
    assign sel_len     = (sel_len_raw > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : sel_len_raw;
    assign sel_data    = req_data[grant_id_reg*PAY_W +: PAY_W];
    assign cur_byte    = payload_reg[idx_reg*8 +: 8];
    assign idx_inc     = idx_reg + LEN_W'(1);
    assign last_byte   = (idx_inc == len_reg);
    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign gap_done    = (cnt_reg == CNT_W'(GAP_CYCLES - 1));
    assign counting    = (state_reg == ST_WAIT) || (state_reg == ST_WAIT_TERM) || (state_reg == ST_GAP);

    assign busy     = (state_reg != ST_IDLE);
    assign grant_id = grant_id_reg;
    assign db_state = state_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
            assign ack[gi] = (state_reg == ST_LOAD) && (grant_id_reg == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        tx_start    = 1'b0;
        tx_data     = 8'h00;
        timeout_err = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (enable && arb_any) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                state_next = (sel_len == '0) ? ST_AFTER_PAYLOAD : ST_SEND;
            end
            ST_SEND: begin
                tx_start   = 1'b1;
                tx_data    = cur_byte;
                state_next = ST_WAIT;
            end
            // tx_done is checked first so it wins over a same-cycle timeout.
            ST_WAIT: begin
                if (tx_done) begin
`ifdef SERIAL_TX_SCHEDULER_CHECKSUM_EN
                    if (in_chk_reg) state_next = ST_TERM;
                    else
`endif
                    if (last_byte) state_next = ST_AFTER_PAYLOAD;
                    else           state_next = ST_SEND;
                end else if (timeout_hit) begin
                    timeout_err = 1'b1;
                    state_next  = ST_GAP;
                end
            end
`ifdef SERIAL_TX_SCHEDULER_CHECKSUM_EN
            ST_CHK: begin
                tx_start   = 1'b1;
                tx_data    = chk_reg;
                state_next = ST_WAIT;
            end
`endif
            ST_TERM: begin
                tx_start   = 1'b1;
                tx_data    = TERM_BYTE;
                state_next = ST_WAIT_TERM;
            end
            ST_WAIT_TERM: begin
                if (tx_done) begin
                    state_next = ST_GAP;
                end else if (timeout_hit) begin
                    timeout_err = 1'b1;
                    state_next  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            len_reg      <= '0;
            payload_reg  <= '0;
            grant_id_reg <= 2'd0;
            ptr_reg      <= 2'd0;
`ifdef SERIAL_TX_SCHEDULER_CHECKSUM_EN
            chk_reg      <= 8'h00;
            in_chk_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            // One shared counter: restarts on every state change, runs only while waiting.
            if (counting && (state_next == state_reg)) cnt_reg <= cnt_reg + CNT_W'(1);
            else                                       cnt_reg <= '0;

            case (state_reg)
                ST_IDLE: begin
                    if (state_next == ST_LOAD) grant_id_reg <= arb_idx;
                end
                ST_LOAD: begin
                    payload_reg <= sel_data;
                    len_reg     <= sel_len;
                    idx_reg     <= '0;
                    ptr_reg     <= (grant_id_reg == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id_reg + 2'd1;
`ifdef SERIAL_TX_SCHEDULER_CHECKSUM_EN
                    chk_reg     <= 8'h00;
                    in_chk_reg  <= 1'b0;
`endif
                end
`ifdef SERIAL_TX_SCHEDULER_CHECKSUM_EN
                ST_SEND: chk_reg    <= chk_reg ^ cur_byte;
                ST_CHK:  in_chk_reg <= 1'b1;
`endif
                ST_WAIT: begin
                    if (tx_done) idx_reg <= idx_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed bench for serial_tx_scheduler with a simple transmitter model.
// Expectations follow SERIAL_TX_SCHEDULER_CHECKSUM_EN when it is defined.
module tb_serial_tx_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic [2:0]  req = '0;
    logic [8:0]  req_len = '0;
    logic [95:0] req_data = '0;
    logic        tx_done = 1'b0;
    logic [2:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;
    logic [2:0]  db_state;

    serial_tx_scheduler #(
        .NUM_REQ(3), .MAX_BYTES(4), .GAP_CYCLES(50), .TIMEOUT_CYCLES(100), .TERM_BYTE(8'h23)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .req(req), .req_len(req_len),
        .req_data(req_data), .ack(ack), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err),
        .db_state(db_state)
    );

    always #5 clock = ~clock;

    int         tests_run = 0;
    int         failed = 0;
    int         cycle = 0;
    logic [7:0] byte_q[$];
    int         start_cyc[$];
    int         grant_log[$];
    int         ack_cnt[3] = '{0, 0, 0};
    int         toerr_cnt = 0;
    int         done_delay = 10;
    bit         model_on = 1'b1;
    int         cd = -1;

    always @(posedge clock) cycle <= cycle + 1;

    // Transmitter model: tx_done arrives done_delay cycles after each tx_start.
    always @(negedge clock) begin
        tx_done = 1'b0;
        if (!reset) begin
            cd = -1;
        end else if (tx_start) begin
            byte_q.push_back(tx_data);
            start_cyc.push_back(cycle);
            $display("[TB] tx byte %02h at cycle %0d", tx_data, cycle);
            cd = done_delay;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                tx_done = model_on;
                cd = -1;
            end
        end
        if (|ack) grant_log.push_back(int'(grant_id));
        for (int i = 0; i < 3; i++) if (ack[i]) ack_cnt[i]++;
        if (timeout_err) toerr_cnt++;
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] len, input logic [31:0] data);
        req_len[i*3 +: 3]   = len;
        req_data[i*32 +: 32] = data;
    endtask

    task automatic wait_st(input logic [2:0] st, input int budget, input string tag);
        int n = 0;
        while (db_state !== st && n < budget) begin
            tick();
            n++;
        end
        check(tag, {29'd0, db_state}, {29'd0, st});
    endtask

    task automatic check_bytes(input string tag, input int n, input logic [31:0] exp);
        check({tag, "_count"}, byte_q.size(), n);
        for (int i = 0; i < n; i++)
            if (i < byte_q.size()) check(tag, {24'd0, byte_q[i]}, {24'd0, exp[i*8 +: 8]});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        byte_q.delete();
        start_cyc.delete();
        grant_log.delete();
        for (int i = 0; i < 3; i++) ack_cnt[i] = 0;
    endtask

    initial begin
        int n;
        int saved;

        // Reset state
        tick(); tick(); tick();
        check("rst_ack", {29'd0, ack}, 0);
        check("rst_tx_start", {31'd0, tx_start}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_grant_id", {30'd0, grant_id}, 0);
        check("rst_timeout_err", {31'd0, timeout_err}, 0);
        check("rst_db_state", {29'd0, db_state}, 0);
        reset = 1'b1;
        tick();

        // Single request: two payload bytes
        set_req(1, 3'd2, 32'h0000_4241);
        req = 3'b010;
        tick();
        check("t1_ack", {29'd0, ack}, 32'h2);
        check("t1_grant_id", {30'd0, grant_id}, 1);
        check("t1_db_load", {29'd0, db_state}, 1);
        req = 3'b000;
        tick();
        check("t1_tx_start", {31'd0, tx_start}, 1);
        check("t1_tx_data", {24'd0, tx_data}, 32'h41);
        req_data = '1;
        wait_st(3'd6, 200, "t1_reach_gap");
        n = 0;
        while (db_state === 3'd6 && n < 100) begin
            tick();
            n++;
        end
        check("t1_gap_len", n, 50);
        check("t1_busy_after", {31'd0, busy}, 0);
`ifdef SERIAL_TX_SCHEDULER_CHECKSUM_EN
        check_bytes("t1_bytes", 4, 32'h2303_4241);
`else
        check_bytes("t1_bytes", 3, 32'h0023_4241);
`endif
        if (start_cyc.size() >= 2) check("t1_restart_lat", start_cyc[1] - start_cyc[0], 11);
        else check("t1_restart_lat", start_cyc.size(), 2);
        check("t1_ack_cnt", ack_cnt[1], 1);

        // Round-robin with all requests held
        do_reset();
        done_delay = 2;
        set_req(0, 3'd1, 32'hA0);
        set_req(1, 3'd1, 32'hA1);
        set_req(2, 3'd1, 32'hA2);
        req = 3'b111;
        n = 0;
        while (grant_log.size() < 6 && n < 1000) begin
            tick();
            n++;
        end
        req = 3'b000;
        check("t2_grants", grant_log.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < grant_log.size()) check("t2_order", grant_log[i], i % 3);
        for (int i = 0; i < 3; i++) check("t2_ack_cnt", ack_cnt[i], 2);
        wait_st(3'd6, 200, "t2_reach_gap");
        wait_st(3'd0, 100, "t2_idle");

        // Zero-length frame on requester 2
        byte_q.delete();
        set_req(2, 3'd0, 32'h0);
        req = 3'b100;
        tick();
        check("t3_ack", {29'd0, ack}, 32'h4);
        req = 3'b000;
        wait_st(3'd6, 200, "t3_reach_gap");
        wait_st(3'd0, 100, "t3_idle");
`ifdef SERIAL_TX_SCHEDULER_CHECKSUM_EN
        check_bytes("t3_bytes", 2, 32'h0000_2300);
`else
        check_bytes("t3_bytes", 1, 32'h0000_0023);
`endif

        // Timeout: transmitter never answers
        byte_q.delete();
        done_delay = 10;
        model_on = 1'b0;
        set_req(0, 3'd1, 32'h55);
        req = 3'b001;
        n = 0;
        while (tx_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("t4_start_seen", {31'd0, tx_start}, 1);
        req = 3'b000;
        n = 0;
        do begin
            tick();
            n++;
        end while (timeout_err !== 1'b1 && n < 300);
        check("t4_timeout_lat", n, 100);
        check("t4_state_wait", {29'd0, db_state}, 3);
        tick();
        check("t4_state_gap", {29'd0, db_state}, 6);
        check("t4_err_pulse", {31'd0, timeout_err}, 0);
        wait_st(3'd0, 100, "t4_idle");
        check_bytes("t4_no_term", 1, 32'h55);
        model_on = 1'b1;
        set_req(1, 3'd1, 32'h77);
        req = 3'b010;
        tick();
        check("t4_next_ack", {29'd0, ack}, 32'h2);
        req = 3'b000;
        wait_st(3'd6, 200, "t4_reach_gap2");
        wait_st(3'd0, 100, "t4_idle2");
`ifdef SERIAL_TX_SCHEDULER_CHECKSUM_EN
        check_bytes("t4_bytes", 4, 32'h2377_7755);
`else
        check_bytes("t4_bytes", 3, 32'h0023_7755);
`endif
        check("t4_err_cnt", toerr_cnt, 1);

        // Reset during the wait of the second byte
        byte_q.delete();
        set_req(1, 3'd2, 32'h0000_BBAA);
        req = 3'b010;
        tick();
        check("t5_ack", {29'd0, ack}, 32'h2);
        req = 3'b000;
        n = 0;
        while (byte_q.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        tick();
        check("t5_in_wait", {29'd0, db_state}, 3);
        reset = 1'b0;
        tick();
        check("t5_ack0", {29'd0, ack}, 0);
        check("t5_tx_start0", {31'd0, tx_start}, 0);
        check("t5_tx_data0", {24'd0, tx_data}, 0);
        check("t5_busy0", {31'd0, busy}, 0);
        check("t5_grant_id0", {30'd0, grant_id}, 0);
        check("t5_timeout0", {31'd0, timeout_err}, 0);
        check("t5_db_state0", {29'd0, db_state}, 0);
        reset = 1'b1;
        tick(); tick(); tick();
        check_bytes("t5_no_term", 2, 32'h0000_BBAA);
        check("t5_err_cnt", toerr_cnt, 1);
        set_req(0, 3'd1, 32'h11);
        set_req(2, 3'd1, 32'h22);
        req = 3'b101;
        tick();
        check("t5_ptr_zero", {29'd0, ack}, 32'h1);
        req = 3'b000;
        wait_st(3'd6, 200, "t5_reach_gap");
        wait_st(3'd0, 100, "t5_idle");

        // enable low holds off grants
        enable = 1'b0;
        saved = ack_cnt[1];
        set_req(1, 3'd1, 32'h33);
        req = 3'b010;
        for (int i = 0; i < 5; i++) tick();
        check("t6_no_busy", {31'd0, busy}, 0);
        check("t6_no_ack", ack_cnt[1], saved);
        enable = 1'b1;
        tick();
        check("t6_ack", {29'd0, ack}, 32'h2);
        req = 3'b000;
        wait_st(3'd6, 200, "t6_reach_gap");
        wait_st(3'd0, 100, "t6_idle");

`ifdef SERIAL_TX_SCHEDULER_CHECKSUM_EN
        // Checksum byte
        byte_q.delete();
        set_req(0, 3'd2, 32'h0000_F00F);
        req = 3'b001;
        tick();
        req = 3'b000;
        wait_st(3'd6, 200, "t7_reach_gap");
        wait_st(3'd0, 100, "t7_idle");
        check_bytes("t7_bytes", 4, 32'h23FF_F00F);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
